// File: rtl/issue_pkg.sv
// Types and helpers shared by the in-order issuer and its per-branch slots.
`include "instr_dec.vh"

package issue_pkg;

  localparam int COMMIT_ID_W = 9;
  localparam int N_BRANCHES  = `N_INSTR_BRANCHES;
  localparam int BRANCH_W    = (N_BRANCHES > 1) ? $clog2(N_BRANCHES) : 1;

  typedef logic [COMMIT_ID_W-1:0] commit_id_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } issue_state_e;

  // Commit IDs live on a 512-entry ring, so plain subtraction wraps correctly.
  function automatic commit_id_t id_diff(input commit_id_t a, input commit_id_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/instr_dec.vh
// Execution-branch enumeration shared by the sequencer, issuer and commit engine.
`ifndef INSTR_DEC_VH
`define INSTR_DEC_VH

`define N_INSTR_BRANCHES   4
`define INSTR_BRANCH_ALU   0
`define INSTR_BRANCH_MAC   1
`define INSTR_BRANCH_LUT   2
`define INSTR_BRANCH_MEM   3

`endif

// File: rtl/issue_slot.sv
// One-entry valid/ready holding register between the issuer and one execution branch.
module issue_slot
  import issue_pkg::*;
#(
  parameter int block_w   = 8,
  parameter int payload_w = 48
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 ready_i,
  input  logic [block_w-1:0]   block_i,
  input  logic [3:0]           dest_i,
  input  commit_id_t           commit_id_i,
  input  logic                 commit_flag_i,
  input  logic [payload_w-1:0] payload_i,
  output logic                 valid_o,
  output logic [block_w-1:0]   block_o,
  output logic [3:0]           dest_o,
  output commit_id_t           commit_id_o,
  output logic                 commit_flag_o,
  output logic [payload_w-1:0] payload_o
);

  logic                 valid_q, valid_d;
  logic [block_w-1:0]   block_q;
  logic [3:0]           dest_q;
  commit_id_t           commit_id_q;
  logic                 commit_flag_q;
  logic [payload_w-1:0] payload_q;

  // A reload in the same cycle as a drain wins, so back-to-back issue keeps valid high.
  always_comb begin
    valid_d = valid_q;
    if (load_i) begin
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: the data registers are reset too, because the outputs must read zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q       <= 1'b0;
      block_q       <= '0;
      dest_q        <= '0;
      commit_id_q   <= '0;
      commit_flag_q <= 1'b0;
      payload_q     <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        block_q       <= block_i;
        dest_q        <= dest_i;
        commit_id_q   <= commit_id_i;
        commit_flag_q <= commit_flag_i;
        payload_q     <= payload_i;
      end
    end
  end

  assign valid_o       = valid_q;
  assign block_o       = block_q;
  assign dest_o        = dest_q;
  assign commit_id_o   = commit_id_q;
  assign commit_flag_o = commit_flag_q;
  assign payload_o     = payload_q;

endmodule

// File: rtl/issue_master.sv
// In-order issuer: tags instructions with commit IDs and dispatches them per branch.
// Define ISSUE_OVERRUN_COUNT_EN to add the saturating overrun_count output.
module issue_master
  import issue_pkg::*;
#(
  parameter int data_width      = 16,
  parameter int n_blocks        = 256,
  parameter int payload_width   = 48,
  parameter int max_outstanding = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        sample_tick,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [BRANCH_W-1:0]         instr_branch,
  input  logic [$clog2(n_blocks)-1:0] instr_block,
  input  logic [3:0]                  instr_dest,
  input  logic                        instr_commit_flag,
  input  logic [payload_width-1:0]    instr_payload,
  input  logic                        instr_last,
  output logic [N_BRANCHES-1:0]       out_valid,
  input  logic [N_BRANCHES-1:0]       out_ready,
  output logic [$clog2(n_blocks)-1:0] out_block [N_BRANCHES],
  output logic [3:0]                  out_dest [N_BRANCHES],
  output commit_id_t                  out_commit_id [N_BRANCHES],
  output logic [N_BRANCHES-1:0]       out_commit_flag,
  output logic [payload_width-1:0]    out_payload [N_BRANCHES],
  input  commit_id_t                  next_commit_id,
  output commit_id_t                  issue_id,
  output commit_id_t                  outstanding,
  output logic                        frame_done,
  output logic                        busy,
  output logic                        overrun
`ifdef ISSUE_OVERRUN_COUNT_EN
  ,
  output logic [15:0]                 overrun_count
`endif
);

  localparam int         BLOCK_W = $clog2(n_blocks);
  localparam commit_id_t MAX_OUT = commit_id_t'(max_outstanding);

  if (max_outstanding < 1 || max_outstanding > 256) begin : g_bad_max_outstanding
    $error("issue_master: max_outstanding must be within 1..256");
  end
  if (payload_width < data_width) begin : g_bad_payload_width
    $error("issue_master: payload_width must hold at least one data_width operand");
  end

  issue_state_e          state_q, state_d;
  commit_id_t            issue_id_q, issue_id_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_done_q, frame_done_d;
  logic                  rdy;
  logic                  room;
  logic                  slots_empty;
  logic                  tick_busy;
  logic [N_BRANCHES-1:0] load;

  assign outstanding = id_diff(issue_id_q, next_commit_id);
  assign room        = outstanding < MAX_OUT;
  assign slots_empty = ~|out_valid;
  // A new sample period while the previous program is still in flight.
  assign tick_busy   = enable && sample_tick && (state_q != IDLE);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    issue_id_d   = issue_id_q;
    overrun_d    = overrun_q || tick_busy;
    frame_done_d = 1'b0;
    rdy          = 1'b0;
    load         = '0;
    case (state_q)
      IDLE: begin
        if (enable && sample_tick) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rdy = enable && !sample_tick && room &&
              (!out_valid[instr_branch] || out_ready[instr_branch]);
        if (instr_valid && rdy) begin
          load[instr_branch] = 1'b1;
          issue_id_d         = issue_id_q + 1'b1;
          if (instr_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (enable && slots_empty && (next_commit_id == issue_id_q)) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      issue_id_q   <= '0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_id_q   <= issue_id_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  for (genvar b = 0; b < N_BRANCHES; b++) begin : g_slot
    issue_slot #(
      .block_w  (BLOCK_W),
      .payload_w(payload_width)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .load_i       (load[b]),
      .ready_i      (out_ready[b]),
      .block_i      (instr_block),
      .dest_i       (instr_dest),
      .commit_id_i  (issue_id_q),
      .commit_flag_i(instr_commit_flag),
      .payload_i    (instr_payload),
      .valid_o      (out_valid[b]),
      .block_o      (out_block[b]),
      .dest_o       (out_dest[b]),
      .commit_id_o  (out_commit_id[b]),
      .commit_flag_o(out_commit_flag[b]),
      .payload_o    (out_payload[b])
    );
  end

`ifdef ISSUE_OVERRUN_COUNT_EN
  logic [15:0] ovr_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_cnt_q <= '0;
    end else if (tick_busy && (ovr_cnt_q != 16'hFFFF)) begin
      ovr_cnt_q <= ovr_cnt_q + 16'd1;
    end
  end

  assign overrun_count = ovr_cnt_q;
`endif

  assign instr_ready = rdy;
  assign issue_id    = issue_id_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;

endmodule

// File: doc/issue_master.md
Name: issue_master

Overview:
- In-order instruction issuer: the initiating end of the commit-ID protocol.
- Accepts decoded instructions from the program sequencer once per sample and tags each with a sequential 9-bit commit ID.
- Dispatches each instruction to its execution branch over per-branch valid/ready.
- Bounds in-flight instructions against the commit engine's next_commit_id feedback; reports frame completion and sample overruns.

Parameters:
- data_width, 16, sample/operand width.
- n_blocks, 256, number of program blocks; block index width is $clog2(n_blocks).
- payload_width, 48, opaque operand/opcode bundle carried to the branch.
- max_outstanding, 16, maximum issued-but-uncommitted instructions; legal range 1..256.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  global run enable; when low, no acceptance and no state change except reset.
- sample_tick  in  1  one-cycle pulse marking a new sample period.
- instr_valid  in  1  sequencer has an instruction.
- instr_ready  out  1  instruction accepted this cycle when high together with instr_valid.
- instr_branch  in  $clog2(`N_INSTR_BRANCHES)  target branch.
- instr_block  in  $clog2(n_blocks)  block index.
- instr_dest  in  4  destination channel.
- instr_commit_flag  in  1  per-instruction flag forwarded to the commit engine (MAC: overwrite accumulator).
- instr_payload  in  payload_width  operands/opcode.
- instr_last  in  1  last instruction of the sample program.
- out_valid  out  `N_INSTR_BRANCHES  per-branch valid.
- out_ready  in  `N_INSTR_BRANCHES  per-branch ready.
- out_block  out  array[`N_INSTR_BRANCHES] x $clog2(n_blocks)  block index per branch.
- out_dest  out  array x 4  destination channel per branch.
- out_commit_id  out  array x 9  commit ID per branch.
- out_commit_flag  out  `N_INSTR_BRANCHES  commit flag per branch.
- out_payload  out  array x payload_width  payload per branch.
- next_commit_id  in  9  commit engine's next expected ID.
- issue_id  out  9  ID the next accepted instruction will receive.
- outstanding  out  9  (issue_id - next_commit_id) mod 512.
- frame_done  out  1  one-cycle pulse when the whole sample program has committed.
- busy  out  1  high when state is not IDLE.
- overrun  out  1  sticky; a sample_tick arrived while the issuer was busy.

Behaviour:
- Reset values:
  - state IDLE, issue_id 0, overrun 0, frame_done 0.
  - All out_valid 0; out_* data 0.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - enable && sample_tick -> ISSUE.
  - instr_ready is 0.
- ISSUE:
  - Combinational rule: instr_ready = enable && !sample_tick && outstanding < max_outstanding && (!out_valid[b] || out_ready[b]), where b = instr_branch.
  - On acceptance, the slot for b loads all fields and commit_id <= issue_id; out_valid[b] <= 1; issue_id <= issue_id + 1 (wraps 511->0).
  - Acceptance with instr_last -> DRAIN.
- DRAIN:
  - Slots continue to drain.
  - When no out_valid is set and next_commit_id == issue_id: pulse frame_done for 1 cycle -> IDLE.
- Slots (one per branch):
  - out_valid[b] clears on out_valid[b] && out_ready[b] unless reloaded the same cycle; a same-cycle reload keeps valid high and carries the new data.
  - Data is stable while valid && !ready.
- Latency: acceptance to out_valid is 1 cycle; fully pipelined, one acceptance per cycle maximum.
- outstanding:
  - Combinational from the registered issue_id and the next_commit_id input.
  - Counts instructions held in slots plus those executing in branches.
- Overrun:
  - enable && sample_tick while in ISSUE or DRAIN sets overrun; the state machine is not restarted.
  - overrun is cleared only by reset.
- sample_tick in IDLE with enable low is ignored; that sample period is skipped.
- enable low mid-frame: state and slots freeze; out_valid remains asserted, and a handshake on out_ready still completes.
- Reset mid-operation:
  - All slots are invalidated immediately and in-flight tags are abandoned.
  - The commit engine must be reset in the same cycle.

Optional Feature:
- Macro: ISSUE_OVERRUN_COUNT_EN.
- Defined: adds output overrun_count [15:0]; it increments, saturating at 16'hFFFF, on every overrun event, and resets to 0.
- Undefined: port and counter are absent; only the sticky overrun flag exists.

Decomposition:
- Package issue_pkg contains:
  - State enum {IDLE, ISSUE, DRAIN}.
  - COMMIT_ID_W = 9.
  - The modular ID subtraction function.
- Branch count and branch indices come from the existing `N_INSTR_BRANCHES / `INSTR_BRANCH_* defines in instr_dec.vh.
- Sub-module issue_slot: one-entry valid/ready holding register with load/drain; generated `N_INSTR_BRANCHES times.

Test Plan:
- Reset, then tick, then 3 instructions to branches 0, 1, 0 with out_ready all 1 -> commit IDs 0, 1, 2. Raise next_commit_id to 3 -> frame_done pulse one cycle after the last slot empties; state IDLE.
- Hold out_ready[0]=0, send two instructions to branch 0 -> second stalls with instr_ready=0 and slot data stable. Release -> second issues with ID+1.
- max_outstanding=4, next_commit_id held at 0 -> exactly 4 accepted, instr_ready=0 with outstanding=4. Step next_commit_id to 1 -> one more accepted.
- Preload issue_id to 510 by running frames -> IDs 510, 511, 0 issued; outstanding computed correctly across the wrap (3 with next_commit_id=510).
- sample_tick during DRAIN -> overrun=1, no restart, frame completes normally. With ISSUE_OVERRUN_COUNT_EN, 3 such ticks -> overrun_count=3.
- Assert reset mid-ISSUE with 2 slots valid -> all out_valid=0, issue_id=0, state IDLE in the same cycle (asynchronous).
